// File: rtl/xosera_bus_responder_pkg.sv
// Shared definitions for the Xosera host register bus responder:
// register-number width, bus FSM states and host register numbers.
package xosera_bus_responder_pkg;

    localparam int XV_REG_BITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } bus_state_t;

    localparam logic [3:0] XVID_SYS_CTRL = 4'd0;
    localparam logic [3:0] XVID_INT_CTRL = 4'd1;
    localparam logic [3:0] XVID_TIMER    = 4'd2;
    localparam logic [3:0] XVID_WR_ADDR  = 4'd3;
    localparam logic [3:0] XVID_DATA     = 4'd4;
    localparam logic [3:0] XVID_DATA_2   = 4'd5;
    localparam logic [3:0] XVID_RD_INCR  = 4'd9;

endpackage

// File: rtl/xosera_bus_responder_bus_sync.sv
// N-flop synchronizer for an asynchronous single-bit input with a
// configurable reset value.
module bus_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_r;

    // shift the async input through the synchronizer chain
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_r[STAGES-1];

endmodule

// File: rtl/xosera_bus_responder.sv
// Target side of the 8-bit host register bus: synchronizes cs_n, turns each
// access into one-cycle strobes and returns read bytes with a coherent latch.
module xosera_bus_responder
    import xosera_bus_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int REG_BITS    = XV_REG_BITS
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                bus_cs_n_i,
    input  logic                bus_rd_nwr_i,
    input  logic                bus_bytesel_i,
    input  logic [REG_BITS-1:0] bus_reg_num_i,
    input  logic [7:0]          bus_data_i,
    output logic [7:0]          bus_data_o,
    output logic [REG_BITS-1:0] reg_rd_num_o,
    input  logic [15:0]         reg_rd_data_i,
    output logic                byte_wr_strobe_o,
    output logic                byte_wr_lo_o,
    output logic                reg_wr_strobe_o,
    output logic [REG_BITS-1:0] reg_wr_num_o,
    output logic [15:0]         reg_wr_data_o,
    output logic                reg_rd_strobe_o,
    output logic                reg_rd_lo_o
);

    localparam int FLUSH_BITS = $clog2(SYNC_STAGES + 1);

    bus_state_t             state_r;
    bus_state_t             state_next_s;
    logic                   cs_sync_s;
    logic                   cs_prev_r;
    logic [FLUSH_BITS-1:0]  flush_cnt_r;
    logic                   flush_done_s;
    logic                   access_start_s;
    logic                   strobe_s;

    logic                   cap_rd_r;
    logic                   cap_lo_r;
    logic [REG_BITS-1:0]    cap_num_r;
    logic [7:0]             cap_data_r;

    logic [7:0]             hi_latch_r;
    logic [15:0]            rd_latch_r;
    logic [REG_BITS-1:0]    rd_latch_num_r;
    logic                   rd_latch_valid_r;
    logic [7:0]             rd_byte_s;
    logic [7:0]             bus_data_r;

    bus_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .async_i   (bus_cs_n_i),
        .sync_o    (cs_sync_s)
    );

    // The chain comes out of reset preloaded high; cs_prev_r only tracks it
    // once real samples have flushed through, so a cs_n held low across reset
    // has to rise and fall again before it counts as a new access.
    assign flush_done_s   = (flush_cnt_r == FLUSH_BITS'(SYNC_STAGES));
    assign access_start_s = flush_done_s & cs_prev_r & ~cs_sync_s;

    // edge-detect history and post-reset flush counter
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            flush_cnt_r <= {FLUSH_BITS{1'b0}};
            cs_prev_r   <= 1'b0;
        end else if (!flush_done_s) begin
            flush_cnt_r <= flush_cnt_r + FLUSH_BITS'(1);
            cs_prev_r   <= 1'b0;
        end else begin
            flush_cnt_r <= flush_cnt_r;
            cs_prev_r   <= cs_sync_s;
        end
    end

    // bus FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // bus FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_start_s) begin
                    state_next_s = STROBE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STROBE: state_next_s = HOLD;
            HOLD: begin
                if (cs_sync_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // capture the access attributes on the synchronized cs_n fall
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            cap_rd_r   <= 1'b0;
            cap_lo_r   <= 1'b0;
            cap_num_r  <= {REG_BITS{1'b0}};
            cap_data_r <= 8'h00;
        end else if (state_r == IDLE && access_start_s) begin
            cap_rd_r   <= bus_rd_nwr_i;
            cap_lo_r   <= bus_bytesel_i;
            cap_num_r  <= bus_reg_num_i;
            cap_data_r <= bus_data_i;
        end else begin
            cap_rd_r   <= cap_rd_r;
            cap_lo_r   <= cap_lo_r;
            cap_num_r  <= cap_num_r;
            cap_data_r <= cap_data_r;
        end
    end

    // high-byte write latch and coherent read latch, updated in STROBE
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            hi_latch_r       <= 8'h00;
            rd_latch_r       <= 16'h0000;
            rd_latch_num_r   <= {REG_BITS{1'b0}};
            rd_latch_valid_r <= 1'b0;
        end else if (state_r == STROBE) begin
            if (!cap_rd_r) begin
                if (!cap_lo_r) begin
                    hi_latch_r <= cap_data_r;
                end
                rd_latch_valid_r <= 1'b0;
            end else if (!cap_lo_r) begin
                rd_latch_r       <= reg_rd_data_i;
                rd_latch_num_r   <= cap_num_r;
                rd_latch_valid_r <= 1'b1;
            end else begin
                rd_latch_valid_r <= 1'b0;
            end
        end
    end

    // read byte select: the low half of a latched register wins over live data
    always_comb begin
        rd_byte_s = reg_rd_data_i[7:0];
        if (!bus_bytesel_i) begin
            rd_byte_s = reg_rd_data_i[15:8];
        end else if (rd_latch_valid_r && (rd_latch_num_r == bus_reg_num_i)) begin
            rd_byte_s = rd_latch_r[7:0];
        end else begin
            rd_byte_s = reg_rd_data_i[7:0];
        end
    end

    // registered read data toward the host
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            bus_data_r <= 8'h00;
        end else begin
            bus_data_r <= rd_byte_s;
        end
    end

    assign strobe_s         = (state_r == STROBE);
    assign bus_data_o       = bus_data_r;
    assign reg_rd_num_o     = bus_reg_num_i;
    assign byte_wr_strobe_o = strobe_s & ~cap_rd_r;
    assign byte_wr_lo_o     = cap_lo_r;
    assign reg_wr_strobe_o  = strobe_s & ~cap_rd_r & cap_lo_r;
    assign reg_wr_num_o     = cap_num_r;
    assign reg_wr_data_o    = {hi_latch_r, cap_data_r};
    assign reg_rd_strobe_o  = strobe_s & cap_rd_r;
    assign reg_rd_lo_o      = cap_lo_r;

endmodule

// File: tb/tb_xosera_bus_responder.sv
// Directed bench for xosera_bus_responder: host bus accesses with a small
// strobe monitor and hand-computed expected values.
module tb_xosera_bus_responder;
    import xosera_bus_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_n;
    logic        rd_nwr;
    logic        bytesel;
    logic [3:0]  reg_num;
    logic [7:0]  wdata;
    logic [7:0]  bus_data;
    logic [3:0]  rd_num;
    logic [15:0] rd_data;
    logic        byte_wr_strobe;
    logic        byte_wr_lo;
    logic        reg_wr_strobe;
    logic [3:0]  wr_num;
    logic [15:0] wr_data;
    logic        reg_rd_strobe;
    logic        rd_lo;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int byte_cnt = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int first_strobe_cyc = -1;
    logic [3:0]  wr_num_q [$];
    logic [15:0] wr_data_q[$];
    logic        rd_lo_q  [$];

    xosera_bus_responder dut (
        .clk              (clk),
        .reset_n_i        (reset_n),
        .bus_cs_n_i       (cs_n),
        .bus_rd_nwr_i     (rd_nwr),
        .bus_bytesel_i    (bytesel),
        .bus_reg_num_i    (reg_num),
        .bus_data_i       (wdata),
        .bus_data_o       (bus_data),
        .reg_rd_num_o     (rd_num),
        .reg_rd_data_i    (rd_data),
        .byte_wr_strobe_o (byte_wr_strobe),
        .byte_wr_lo_o     (byte_wr_lo),
        .reg_wr_strobe_o  (reg_wr_strobe),
        .reg_wr_num_o     (wr_num),
        .reg_wr_data_o    (wr_data),
        .reg_rd_strobe_o  (reg_rd_strobe),
        .reg_rd_lo_o      (rd_lo)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc++;

    // strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (byte_wr_strobe) byte_cnt++;
        if (reg_wr_strobe || reg_rd_strobe || byte_wr_strobe) begin
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        end
        if (reg_wr_strobe) begin
            wr_cnt++;
            wr_num_q.push_back(wr_num);
            wr_data_q.push_back(wr_data);
        end
        if (reg_rd_strobe) begin
            rd_cnt++;
            rd_lo_q.push_back(rd_lo);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // one host access; rbyte is bus_data_o sampled shortly after cs_n falls
    task automatic bus_access(input logic rd, input logic lo, input logic [3:0] num,
                              input logic [7:0] dat, input int hold, output logic [7:0] rbyte);
        @(posedge clk); #1;
        rd_nwr = rd; bytesel = lo; reg_num = num; wdata = dat;
        repeat (3) @(posedge clk);
        #1; cs_n = 1'b0; fall_cyc = cyc;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rbyte = bus_data;
        repeat (hold - 2) @(posedge clk);
        #1; cs_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        int         w0;
        int         b0;
        int         r0;

        reset_n = 1'b0; cs_n = 1'b1; rd_nwr = 1'b0; bytesel = 1'b0;
        reg_num = XVID_TIMER; wdata = 8'h5C; rd_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus_data", 32'(bus_data), 32'h0);
        check("reset_strobes", 32'({byte_wr_strobe, reg_wr_strobe, reg_rd_strobe}), 32'h0);
        check("reset_wr_data", 32'(wr_data), 32'h0);
        check("rd_num_comb", 32'(rd_num), 32'(XVID_TIMER));
        #1; reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // WR_ADDR: hi then lo
        bus_access(1'b0, 1'b0, XVID_WR_ADDR, 8'hAB, 6, rb);
        check("wraddr_hi_bytes", 32'(byte_cnt), 32'd1);
        check("wraddr_hi_regwr", 32'(wr_cnt), 32'd0);
        check("strobe_latency", 32'(first_strobe_cyc - fall_cyc), 32'd3);
        bus_access(1'b0, 1'b1, XVID_WR_ADDR, 8'hCD, 6, rb);
        check("wraddr_bytes", 32'(byte_cnt), 32'd2);
        check("wraddr_regwr", 32'(wr_cnt), 32'd1);
        check("wraddr_num", 32'(wr_num_q[0]), 32'(XVID_WR_ADDR));
        check("wraddr_data", 32'(wr_data_q[0]), 32'hABCD);
        check("wraddr_no_rd", 32'(rd_cnt), 32'd0);

        // DATA: three 16-bit writes
        wr_num_q.delete(); wr_data_q.delete(); w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            bus_access(1'b0, 1'b0, XVID_DATA, 8'(8'hD0 + i), 6, rb);
            bus_access(1'b0, 1'b1, XVID_DATA, 8'(8'h70 + i), 6, rb);
        end
        check("data_count", 32'(wr_cnt - w0), 32'd3);
        check("data_0", 32'(wr_data_q[0]), 32'hD070);
        check("data_1", 32'(wr_data_q[1]), 32'hD171);
        check("data_2", 32'(wr_data_q[2]), 32'hD272);

        // coherent 16-bit read of DATA
        rd_lo_q.delete(); r0 = rd_cnt;
        rd_data = 16'hD070;
        bus_access(1'b1, 1'b0, XVID_DATA, 8'h00, 6, rb);
        check("rd_hi", 32'(rb), 32'hD0);
        rd_data = 16'hD171;
        bus_access(1'b1, 1'b1, XVID_DATA, 8'h00, 6, rb);
        check("rd_lo_latched", 32'(rb), 32'h70);
        check("rd_strobes", 32'(rd_cnt - r0), 32'd2);
        check("rd_lo_seq", 32'({rd_lo_q[0], rd_lo_q[1]}), 32'b01);
        bus_access(1'b1, 1'b1, XVID_DATA, 8'h00, 6, rb);
        check("rd_lo_after_clear", 32'(rb), 32'h71);

        // lone low-byte write reuses the shared hi latch
        wr_num_q.delete(); wr_data_q.delete();
        bus_access(1'b0, 1'b0, XVID_WR_ADDR, 8'hAB, 6, rb);
        bus_access(1'b0, 1'b1, XVID_RD_INCR, 8'h34, 6, rb);
        check("lo_only_num", 32'(wr_num_q[0]), 32'(XVID_RD_INCR));
        check("lo_only_data", 32'(wr_data_q[0]), 32'hAB34);

        // latch tagged with reg 4 must not serve reg 5
        rd_data = 16'h1234;
        bus_access(1'b1, 1'b0, XVID_DATA, 8'h00, 6, rb);
        check("rd4_hi", 32'(rb), 32'h12);
        rd_data = 16'h5678;
        bus_access(1'b1, 1'b1, XVID_DATA_2, 8'h00, 6, rb);
        check("rd5_lo_live", 32'(rb), 32'h78);

        // cs_n held low for 200 clk
        w0 = wr_cnt; b0 = byte_cnt;
        bus_access(1'b0, 1'b1, XVID_WR_ADDR, 8'h11, 200, rb);
        check("long_cs_regwr", 32'(wr_cnt - w0), 32'd1);
        check("long_cs_bytes", 32'(byte_cnt - b0), 32'd1);

        // single-clock glitch on cs_n
        w0 = wr_cnt;
        @(posedge clk); #1; cs_n = 1'b0;
        @(posedge clk); #1; cs_n = 1'b1;
        repeat (8) @(posedge clk);
        check("glitch_at_most_one", 32'(wr_cnt - w0 <= 1), 32'd1);

        // reset during HOLD with cs_n still low
        @(posedge clk); #1;
        rd_nwr = 1'b0; bytesel = 1'b1; reg_num = XVID_WR_ADDR; wdata = 8'h5A;
        repeat (3) @(posedge clk);
        #1; cs_n = 1'b0;
        repeat (5) @(posedge clk);
        #1; reset_n = 1'b0; w0 = wr_cnt;
        @(posedge clk); @(negedge clk);
        check("hold_reset_outputs", 32'({bus_data, wr_data, reg_wr_strobe, byte_wr_strobe}), 32'h0);
        #1; reset_n = 1'b1;
        repeat (20) @(posedge clk);
        check("held_cs_ignored", 32'(wr_cnt - w0), 32'd0);
        #1; cs_n = 1'b1;
        repeat (6) @(posedge clk);
        wr_data_q.delete();
        #1; cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #1; cs_n = 1'b1;
        repeat (6) @(posedge clk);
        check("rearm_after_reset", 32'(wr_cnt - w0), 32'd1);
        check("hi_latch_reset", 32'(wr_data_q[0]), 32'h005A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xosera_bus_responder.md
Name: xosera_bus_responder

Overview:
- Target-side end of the 8-bit host register bus: cs_n, rd_nwr, bytesel, reg_num[3:0], data[7:0].
- Synchronizes the asynchronous host strobe into the pixel clock domain.
- Decodes each access into one-cycle byte and word strobes toward the register file / blitter.
- Presents read data back to the host, with a coherent 16-bit read latch.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on bus_cs_n_i; minimum 2.
- REG_BITS, 4, register number width; 16 registers.

Ports:
- clk  in  1  pixel clock; only clock.
- reset_n_i  in  1  synchronous, active-low reset.
- bus_cs_n_i  in  1  async chip-select strobe, active low.
- bus_rd_nwr_i  in  1  1 = read, 0 = write; stable before the cs_n fall.
- bus_bytesel_i  in  1  0 = high byte, 1 = low byte.
- bus_reg_num_i  in  REG_BITS  register number.
- bus_data_i  in  8  write data byte.
- bus_data_o  out  8  read data byte, registered.
- reg_rd_num_o  out  REG_BITS  equals bus_reg_num_i (combinational); register file returns that register's value on reg_rd_data_i.
- reg_rd_data_i  in  16  current value of register reg_rd_num_o.
- byte_wr_strobe_o  out  1  pulses once per byte write.
- byte_wr_lo_o  out  1  bytesel of the byte write.
- reg_wr_strobe_o  out  1  pulses on a completed 16-bit write (low-byte write).
- reg_wr_num_o  out  REG_BITS  register of the current strobe.
- reg_wr_data_o  out  16  {hi_latch, low byte}; low byte also valid during byte_wr_strobe_o.
- reg_rd_strobe_o  out  1  pulses once per read access.
- reg_rd_lo_o  out  1  bytesel of the read; low-byte reads let the register file auto-increment.

Behaviour:
- Reset (reset_n_i = 0 at a clk edge): all strobes = 0; bus_data_o = 0; hi_latch = 0; rd_latch = 0; rd_latch_valid = 0; state = IDLE.
- Reset also preloads the sync chain to 1 (deasserted), so a low cs_n held through reset is ignored until it goes high and falls again.

Capture:
- cs_n passes through SYNC_STAGES flops.
- Access start = synced value 1 -> 0 edge. On that edge, sample rd_nwr, bytesel, reg_num and data into capture regs; the host holds them stable for the whole cs_n low period.

FSM states:
- IDLE: on access start, go to STROBE.
- STROBE: exactly one cycle. Assert the strobes below, then go to HOLD.
- HOLD: stay until synced cs_n = 1, then go to IDLE. A cs_n held low never produces a second strobe.

Write actions (in STROBE):
- bytesel = 0: byte_wr_strobe_o = 1, byte_wr_lo_o = 0; hi_latch <= data; reg_wr_strobe_o stays 0.
- bytesel = 1: byte_wr_strobe_o = 1, byte_wr_lo_o = 1; reg_wr_strobe_o = 1; reg_wr_data_o = {hi_latch, data}.
- hi_latch is shared by all registers and is not cleared after use: a lone low-byte write reuses the last high byte.
- Any write clears rd_latch_valid.

Read actions (in STROBE):
- reg_rd_strobe_o = 1 and reg_rd_lo_o = bytesel.
- bytesel = 0 read of reg R: rd_latch <= reg_rd_data_i, rd_latch_num <= R, rd_latch_valid <= 1.
- bytesel = 1 read: clears rd_latch_valid after the strobe.

bus_data_o (registered every clk, independent of cs_n):
- bytesel = 0: reg_rd_data_i[15:8].
- bytesel = 1, rd_latch_valid and rd_latch_num == reg_num: rd_latch[7:0].
- Otherwise: reg_rd_data_i[7:0].
- Latency from reg_num/bytesel change to output is one clk. The host must present reg_num ≥ 2 clk before cs_n falls.

Timing and boundaries:
- Strobe latency: SYNC_STAGES + 1 clk after the cs_n fall.
- Minimum access cycle: 2*SYNC_STAGES + 2 clk.
- cs_n glitch shorter than SYNC_STAGES clk: at most one strobe; ignored if it never survives the sync chain.
- Reset during STROBE or HOLD: strobes drop in the same cycle and the state returns to IDLE.

Decomposition:
- xv package: REG_BITS default, bus_state_t enum {IDLE, STROBE, HOLD}, register number constants (XVID_DATA etc.) used by the bench.
- Sub-module bus_sync (N-flop synchronizer, reset value 1), reused for any future async inputs.

Test Plan:
- WR_ADDR (3): write hi 0xAB then lo 0xCD -> one byte strobe after the first, then reg_wr_strobe_o for 1 clk with num = 3, data = 0xABCD; no other strobes.
- DATA (4): three 16-bit writes 0xD070, 0xD171, 0xD272 -> exactly three reg_wr strobes with those values, in order.
- Read of DATA with reg_rd_data_i = 0xD070 -> hi read returns 0xD0.
  - reg_rd_data_i then changes to 0xD171 before the lo read -> lo read returns latched 0x70; reg_rd_strobe_o pulses twice, with reg_rd_lo_o = 0 then 1.
- Lo-only write 0x34 to reg 9 after the hi write 0xAB -> data = 0xAB34.
  - Hi read reg 4, then lo read reg 5 -> the lo byte is live reg_rd_data_i[7:0], not the latch.
- cs_n held low for 200 clk -> exactly one strobe.
  - 1-clk cs_n low pulse -> no strobe, or exactly one strobe, never two.
- reset_n_i low during HOLD with cs_n still low -> outputs 0; no strobe until cs_n rises and falls again.
